// File: rtl/sensor_avg_seq_if.sv
// Bundle between the conversion sequencer, the A2D converter and the downstream consumer.
//   en        : round scheduling enable
//   strt/chnl : conversion request and channel select to the A2D
//   cmplt/a2d : A2D completion pulse and result
//   temp_avg, press_avg, rdy, err : published averages, update pulse, timeout flag
// master = sequencer side, slave = converter / environment side.
interface sensor_avg_seq_if;
  logic        en;
  logic        strt;
  logic        chnl;
  logic        cmplt;
  logic [15:0] a2d;
  logic [15:0] temp_avg;
  logic [15:0] press_avg;
  logic        rdy;
  logic        err;

  modport master (
    input  en, cmplt, a2d,
    output strt, chnl, temp_avg, press_avg, rdy, err
  );

  modport slave (
    output en, cmplt, a2d,
    input  strt, chnl, temp_avg, press_avg, rdy, err
  );
endinterface

// File: rtl/sensor_avg_seq.sv
// Conversion sequencer and averager.
// Runs a round of 2*2^NSAMP_LOG2 conversions alternating temperature (CH0) and
// pressure (CH1) every PERIOD idle cycles while enabled. Publishes floor averages
// with a one-cycle rdy pulse, and flags err when the A2D fails to answer in time.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : sensor_avg_seq_if.master (en, strt, chnl, cmplt, a2d, averages, rdy, err)
module sensor_avg_seq #(
  parameter int unsigned PERIOD     = 1024,
  parameter int unsigned NSAMP_LOG2 = 2,
  parameter int unsigned TIMEOUT    = 32
) (
  input logic               clk,
  input logic               rst_n,
  sensor_avg_seq_if.master  bus
);

  localparam int unsigned ACC_W = 16 + NSAMP_LOG2;
  localparam int unsigned IDX_W = NSAMP_LOG2 + 1;
  localparam int unsigned NCONV = 2 ** (NSAMP_LOG2 + 1);
  localparam int unsigned TMR_W = $clog2(PERIOD);
  localparam int unsigned TO_W  = $clog2(TIMEOUT);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PERIOD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCONV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StNext} state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TO_W-1:0]    tout_q, tout_d;
  logic [ACC_W-1:0]   temp_acc_q, temp_acc_d;
  logic [ACC_W-1:0]   press_acc_q, press_acc_d;
  logic [15:0]        temp_avg_q, temp_avg_d;
  logic [15:0]        press_avg_q, press_avg_d;
  logic               rdy_q, rdy_d;
  logic               err_q, err_d;

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    idx_d       = idx_q;
    tout_d      = tout_q;
    temp_acc_d  = temp_acc_q;
    press_acc_d = press_acc_q;
    temp_avg_d  = temp_avg_q;
    press_avg_d = press_avg_q;
    rdy_d       = 1'b0;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          if (tmr_q == TMR_LAST) begin
            tmr_d       = '0;
            temp_acc_d  = '0;
            press_acc_d = '0;
            idx_d       = '0;
            err_d       = 1'b0;
            state_d     = StStart;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end else begin
          tmr_d = '0;
        end
      end
      StStart: begin
        tout_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        // A completion in the final allowed cycle still counts.
        if (bus.cmplt) begin
          if (idx_q[0]) press_acc_d = press_acc_q + ACC_W'(bus.a2d);
          else          temp_acc_d  = temp_acc_q + ACC_W'(bus.a2d);
          state_d = StNext;
        end else if (tout_q == TO_LAST) begin
          err_d   = 1'b1;
          tmr_d   = '0;
          state_d = StIdle;
        end else begin
          tout_d = tout_q + TO_W'(1);
        end
      end
      StNext: begin
        if (idx_q == IDX_LAST) begin
          temp_avg_d  = temp_acc_q[ACC_W-1:NSAMP_LOG2];
          press_avg_d = press_acc_q[ACC_W-1:NSAMP_LOG2];
          rdy_d       = 1'b1;
          tmr_d       = '0;
          state_d     = StIdle;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StStart;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tmr_q       <= '0;
      idx_q       <= '0;
      tout_q      <= '0;
      temp_acc_q  <= '0;
      press_acc_q <= '0;
      temp_avg_q  <= '0;
      press_avg_q <= '0;
      rdy_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      idx_q       <= idx_d;
      tout_q      <= tout_d;
      temp_acc_q  <= temp_acc_d;
      press_acc_q <= press_acc_d;
      temp_avg_q  <= temp_avg_d;
      press_avg_q <= press_avg_d;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
    end
  end

  // strt is a decode of the state flop, so it drops with the asynchronous reset.
  // The conversion index only moves in StNext, which keeps chnl stable through cmplt.
  assign bus.strt      = (state_q == StStart);
  assign bus.chnl      = idx_q[0];
  assign bus.temp_avg  = temp_avg_q;
  assign bus.press_avg = press_avg_q;
  assign bus.rdy       = rdy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_sensor_avg_seq.sv
// Directed self-checking bench for sensor_avg_seq with default parameters.
// Acts as the A2D converter and the consumer; all sampling and driving on negedge.
module tb_sensor_avg_seq;
  localparam int PERIOD  = 1024;
  localparam int TIMEOUT = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   strt_cnt = 0;
  int   rdy_cnt = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [15:0] vals [8];

  sensor_avg_seq_if bus ();

  sensor_avg_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.strt === 1'b1) strt_cnt <= strt_cnt + 1;
    if (bus.rdy === 1'b1)  rdy_cnt  <= rdy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Returns at the negedge inside the strt cycle; t = cycle number, or -1 on expiry.
  task automatic wait_strt(input int budget, output int t);
    t = -1;
    for (int k = 0; k < budget; k++) begin
      if (bus.strt === 1'b1) begin
        t = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("strt_seen", bus.strt, 1'b1);
  endtask

  // One conversion answered lat cycles after strt; spur holds cmplt into the NEXT cycle.
  task automatic do_conv(input int idx, input logic [15:0] val, input int lat, input bit spur,
                         input int exp_t, output int t);
    wait_strt(PERIOD + 200, t);
    chk($sformatf("strt_cycle_%0d", idx), t, exp_t);
    chk($sformatf("chnl_at_strt_%0d", idx), bus.chnl, idx[0]);
    chk("err_at_strt", bus.err, 1'b0);
    repeat (lat) @(negedge clk);
    chk($sformatf("chnl_held_%0d", idx), bus.chnl, idx[0]);
    bus.cmplt = 1'b1;
    bus.a2d   = val;
    @(negedge clk);
    if (!spur) begin
      bus.cmplt = 1'b0;
      bus.a2d   = 16'h0000;
    end else begin
      @(negedge clk);
      bus.cmplt = 1'b0;
      bus.a2d   = 16'h0000;
    end
  endtask

  task automatic do_round(input int lat, input bit spur, input bit drop_en, input int first_exp,
                          input logic [15:0] exp_temp, input logic [15:0] exp_press,
                          output int rdy_t);
    int t, e, base;
    base = strt_cnt;
    e    = first_exp;
    for (int i = 0; i < 8; i++) begin
      do_conv(i, vals[i], lat, spur && (i < 7), e, t);
      e = t + lat + 2;
      if (drop_en && i == 4) bus.en = 1'b0;
    end
    @(negedge clk);
    chk("rdy_pulse", bus.rdy, 1'b1);
    chk("temp_avg", bus.temp_avg, exp_temp);
    chk("press_avg", bus.press_avg, exp_press);
    chk("err_round", bus.err, 1'b0);
    chk("strt_count", strt_cnt - base, 8);
    rdy_t = cyc;
    @(negedge clk);
    chk("rdy_single", bus.rdy, 1'b0);
  endtask

  initial begin
    int e, t, rdy_t, saved, to_t;
    rst_n     = 1'b0;
    bus.en    = 1'b0;
    bus.cmplt = 1'b0;
    bus.a2d   = 16'h0000;

    // Reset values
    @(negedge clk);
    chk("rst_strt", bus.strt, 1'b0);
    chk("rst_chnl", bus.chnl, 1'b0);
    chk("rst_rdy", bus.rdy, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_temp", bus.temp_avg, 16'h0000);
    chk("rst_press", bus.press_avg, 16'h0000);
    rst_n = 1'b1;

    // Disabled: no conversions
    repeat (5000) @(negedge clk);
    chk("idle_no_strt", strt_cnt, 0);

    // Nominal round, latency 14, first strt PERIOD cycles after en
    bus.en = 1'b1;
    e = cyc;
    vals = '{16'h1ABC, 16'h3456, 16'h1ABC, 16'h3ABC, 16'h1ABC, 16'h6ABC, 16'h1ABC, 16'h5ABC};
    do_round(14, 1'b0, 1'b0, e + PERIOD, 16'h1ABC, 16'h4D22, rdy_t);

    // Spurious cmplt in IDLE, then truncation round with cmplt also held through NEXT
    // and en dropped after the fifth conversion
    repeat (100) @(negedge clk);
    bus.cmplt = 1'b1;
    bus.a2d   = 16'hFFFF;
    @(negedge clk);
    bus.cmplt = 1'b0;
    bus.a2d   = 16'h0000;
    vals = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000};
    do_round(14, 1'b1, 1'b1, rdy_t + PERIOD, 16'hFFFF, 16'h0000, rdy_t);

    // Scheduling halted until en returns
    saved = strt_cnt;
    repeat (3000) @(negedge clk);
    chk("en_low_no_strt", strt_cnt, saved);
    bus.en = 1'b1;
    e = cyc;

    // Timeout on the third conversion
    saved = rdy_cnt;
    do_conv(0, 16'h1111, 14, 1'b0, e + PERIOD, t);
    do_conv(1, 16'h2222, 14, 1'b0, t + 16, t);
    e = t + 16;
    wait_strt(PERIOD + 200, t);
    chk("to_strt_cycle", t, e);
    chk("to_chnl", bus.chnl, 1'b0);
    repeat (TIMEOUT) @(negedge clk);
    chk("to_err_before", bus.err, 1'b0);
    @(negedge clk);
    chk("to_err_set", bus.err, 1'b1);
    chk("to_no_rdy", bus.rdy, 1'b0);
    chk("to_temp_kept", bus.temp_avg, 16'hFFFF);
    chk("to_press_kept", bus.press_avg, 16'h0000);
    to_t = cyc;
    repeat (500) @(negedge clk);
    chk("to_err_held", bus.err, 1'b1);
    chk("to_rdy_count", rdy_cnt, saved);

    // Recovery round answering exactly at the timeout limit
    vals = '{16'h0010, 16'h8000, 16'h0020, 16'h8000, 16'h0030, 16'h8000, 16'h0041, 16'h8000};
    do_round(TIMEOUT, 1'b0, 1'b0, to_t + PERIOD, 16'h0028, 16'h8000, rdy_t);

    // Asynchronous reset in the middle of WAIT
    do_conv(0, 16'h0123, 14, 1'b0, rdy_t + PERIOD, t);
    wait_strt(PERIOD + 200, t);
    chk("ar_chnl_before", bus.chnl, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_strt", bus.strt, 1'b0);
    chk("ar_chnl", bus.chnl, 1'b0);
    chk("ar_rdy", bus.rdy, 1'b0);
    chk("ar_err", bus.err, 1'b0);
    chk("ar_temp", bus.temp_avg, 16'h0000);
    chk("ar_press", bus.press_avg, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
